block_frame_writer: RTL and testbench



---
 rtl/vga_pkg.sv | 20 ++
 rtl/bounce_axis.sv | 36 +++
 rtl/block_frame_writer.sv | 153 +++++++++++++++
 tb/tb_block_frame_writer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA / block-grid constants and types for the 32x24 block framebuffer path.
// Pure declarations, so there is no latency and no flow control.
package vga_pkg;

   localparam int HPIXELS    = 640;
   localparam int VPIXELS    = 480;
   localparam int BLOCK_SIZE = 20;
   localparam int GRID_COLS  = HPIXELS / BLOCK_SIZE;
   localparam int GRID_ROWS  = VPIXELS / BLOCK_SIZE;
   localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      UPDATE
   } state_t;

   typedef logic [7:0] colour_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing object: position 0..MAX that reverses direction at either end.
// Moves one cell per step pulse and is never stalled.
module bounce_axis #(
   parameter int MAX  = 30,
   parameter int INIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   output logic [4:0] pos,
   output logic       dir
);

   localparam logic [4:0] MAX_POS  = 5'(MAX);
   localparam logic [4:0] INIT_POS = 5'(INIT);

   logic flip;
   logic dir_nxt;

   // The direction is turned around before the move, so pos stays within 0..MAX.
   always_comb begin
      flip    = (dir && (pos == MAX_POS)) || (!dir && (pos == 5'd0));
      dir_nxt = dir ^ flip;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos <= INIT_POS;
         dir <= 1'b1;
      end else if (step) begin
         dir <= dir_nxt;
         pos <= dir_nxt ? pos + 5'd1 : pos - 5'd1;
      end
   end

endmodule

// File: rtl/block_frame_writer.sv
// Sweeps all grid cells into the back buffer at one cell per clock, then steps the bouncing object.
// Cell 0 appears on the outputs one cycle after frame start; the framebuffer accepts a write every cycle.
module block_frame_writer
   import vga_pkg::*;
#(
   parameter int      COLS         = GRID_COLS,
   parameter int      ROWS         = GRID_ROWS,
   parameter int      OBJ_SIZE     = 2,
   parameter int      X0           = 4,
   parameter int      Y0           = 3,
   parameter int      FRAME_DIV    = 4,
   parameter colour_t BG_COLOR     = 8'h00,
   parameter colour_t BORDER_COLOR = 8'hFF,
   parameter colour_t FG_COLOR     = 8'hE0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hc,
   input  logic [9:0] vc,
   input  logic       run,
   output logic [9:0] write_addr,
   output logic [7:0] pixel_data,
   output logic       busy,
   output logic       frame_done
);

   localparam int              DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [9:0]      LAST_ADDR = 10'(COLS * ROWS - 1);
   localparam logic [4:0]      LAST_COL  = 5'(COLS - 1);
   localparam logic [4:0]      LAST_ROW  = 5'(ROWS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   state_t           state;
   state_t           state_nxt;
   logic             fs;
   logic             load;
   logic             advance;
   logic             step;
   logic [4:0]       col;
   logic [4:0]       row;
   logic [4:0]       col_nxt;
   logic [4:0]       row_nxt;
   colour_t          colour_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       obj_x;
   logic [4:0]       obj_y;
   logic             dir_x;
   logic             dir_y;
   logic             unused_dirs;

   function automatic logic in_span(input logic [4:0] c, input logic [4:0] lo);
      return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + 6'(OBJ_SIZE)));
   endfunction

   assign fs          = (hc == 10'd0) && (vc == 10'd0);
   assign unused_dirs = dir_x ^ dir_y;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // A frame start in SWEEP restarts the sweep; one in UPDATE is dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fs) state_nxt = SWEEP;
         SWEEP:   if (!fs && (write_addr == LAST_ADDR)) state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load       = 1'b0;
      advance    = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: load = fs;
         SWEEP: begin
            busy    = 1'b1;
            load    = fs;
            advance = !fs && (write_addr != LAST_ADDR);
         end
         UPDATE:  frame_done = 1'b1;
         default: ;
      endcase
   end

   // col/row track the cell presented on write_addr; the _nxt pair is the cell being registered.
   always_comb begin
      col_nxt = col;
      row_nxt = row;
      if (load) begin
         col_nxt = 5'd0;
         row_nxt = 5'd0;
      end else if (col == LAST_COL) begin
         col_nxt = 5'd0;
         row_nxt = row + 5'd1;
      end else begin
         col_nxt = col + 5'd1;
      end
   end

   always_comb begin
      colour_nxt = BG_COLOR;
      if (in_span(col_nxt, obj_x) && in_span(row_nxt, obj_y))
         colour_nxt = FG_COLOR;
      else if ((col_nxt == 5'd0) || (col_nxt == LAST_COL) || (row_nxt == 5'd0) || (row_nxt == LAST_ROW))
         colour_nxt = BORDER_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_addr <= 10'd0;
         pixel_data <= 8'h00;
         col        <= 5'd0;
         row        <= 5'd0;
      end else if (load || advance) begin
         write_addr <= load ? 10'd0 : write_addr + 10'd1;
         pixel_data <= colour_nxt;
         col        <= col_nxt;
         row        <= row_nxt;
      end
   end

   assign step = frame_done && run && (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset)
         div_cnt <= '0;
      else if (frame_done && run)
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
   end

   bounce_axis #(.MAX(COLS - OBJ_SIZE), .INIT(X0)) u_axis_x (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .pos   (obj_x),
      .dir   (dir_x)
   );

   bounce_axis #(.MAX(ROWS - OBJ_SIZE), .INIT(Y0)) u_axis_y (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .pos   (obj_y),
      .dir   (dir_y)
   );

endmodule

// File: tb/tb_block_frame_writer.sv
// Bench for block_frame_writer: two instances (default, and X0=29 / FRAME_DIV=1) share stimulus
// and are checked against a cell-colour / bouncing-object model derived from the grid rules.
module tb_block_frame_writer;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [9:0] hc;
   logic [9:0] vc;
   logic [9:0] wa0, wa1;
   logic [7:0] pd0, pd1;
   logic       busy0, busy1;
   logic       fd0, fd1;

   int errors = 0;
   int checks = 0;

   int xm[2], ym[2], vxm[2], vym[2], divm[2];
   int fdiv[2] = '{4, 1};
   int x0m[2]  = '{4, 29};
   logic [7:0] cap [2][768];

   always #5 clk = ~clk;

   block_frame_writer dut_a (
      .clk(clk), .reset(reset), .hc(hc), .vc(vc), .run(run),
      .write_addr(wa0), .pixel_data(pd0), .busy(busy0), .frame_done(fd0)
   );

   block_frame_writer #(.X0(29), .FRAME_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .hc(hc), .vc(vc), .run(run),
      .write_addr(wa1), .pixel_data(pd1), .busy(busy1), .frame_done(fd1)
   );

   function automatic logic [9:0] get_wa(int d);
      return (d == 0) ? wa0 : wa1;
   endfunction
   function automatic logic [7:0] get_pd(int d);
      return (d == 0) ? pd0 : pd1;
   endfunction
   function automatic logic get_busy(int d);
      return (d == 0) ? busy0 : busy1;
   endfunction
   function automatic logic get_fd(int d);
      return (d == 0) ? fd0 : fd1;
   endfunction

   // Colour of cell a for an object whose top-left corner is (ox, oy).
   function automatic logic [7:0] cell_colour(int a, int ox, int oy);
      int c;
      int r;
      c = a % 32;
      r = a / 32;
      if (c >= ox && c < ox + 2 && r >= oy && r < oy + 2) return 8'hE0;
      if (c == 0 || c == 31 || r == 0 || r == 23) return 8'hFF;
      return 8'h00;
   endfunction

   function automatic int first_fg(int d);
      for (int i = 0; i < 768; i++)
         if (cap[d][i] === 8'hE0) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         xm[d] = x0m[d]; ym[d] = 3; vxm[d] = 1; vym[d] = 1; divm[d] = 0;
      end
   endtask

   task automatic model_update(input bit r);
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            divm[d]++;
            if (divm[d] == fdiv[d]) begin
               divm[d] = 0;
               if ((vxm[d] > 0 && xm[d] == 30) || (vxm[d] < 0 && xm[d] == 0)) vxm[d] = -vxm[d];
               xm[d] += vxm[d];
               if ((vym[d] > 0 && ym[d] == 22) || (vym[d] < 0 && ym[d] == 0)) vym[d] = -vym[d];
               ym[d] += vym[d];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic random_hv();
      hc = 10'($urandom_range(1, 799));
      vc = 10'($urandom_range(0, 524));
   endtask

   task automatic pulse_fs();
      hc = 10'd0;
      vc = 10'd0;
      tick();
      random_hv();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      random_hv();
      tick();
      reset = 1'b0;
      model_reset();
      tick();
   endtask

   // One complete frame: fs, 768 sweep cycles, UPDATE cycle, then the idle hold.
   task automatic do_frame(input bit run_v, input bit fs_upd);
      int bb[2], ba[2], bc[2], bf[2], fc[2];
      int hold_bad;
      logic [7:0] want;
      for (int d = 0; d < 2; d++) begin
         bb[d] = 0; ba[d] = 0; bc[d] = 0; bf[d] = 0; fc[d] = -1;
      end
      run = run_v;
      pulse_fs();
      for (int i = 0; i < 768; i++) begin
         for (int d = 0; d < 2; d++) begin
            want = cell_colour(i, xm[d], ym[d]);
            cap[d][i] = get_pd(d);
            if (get_busy(d) !== 1'b1) bb[d]++;
            if (get_wa(d) !== 10'(i)) ba[d]++;
            if (get_pd(d) !== want) begin
               if (fc[d] < 0) fc[d] = i;
               bc[d]++;
            end
            if (get_fd(d) !== 1'b0) bf[d]++;
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (bb[d] != 0) begin
            errors++;
            $display("FAIL sweep_busy dut%0d: busy low in %0d sweep cycles, want 0", d, bb[d]);
         end
         checks++;
         if (ba[d] != 0) begin
            errors++;
            $display("FAIL sweep_addr dut%0d: %0d out-of-order addresses, want 0", d, ba[d]);
         end
         checks++;
         if (bc[d] != 0) begin
            errors++;
            $display("FAIL sweep_colour dut%0d: %0d wrong cells, first at addr %0d, obj model (%0d,%0d)",
                     d, bc[d], fc[d], xm[d], ym[d]);
         end
         checks++;
         if (bf[d] != 0) begin
            errors++;
            $display("FAIL sweep_frame_done dut%0d: frame_done high in %0d sweep cycles, want 0", d, bf[d]);
         end
         checks++;
         if (get_fd(d) !== 1'b1) begin
            errors++;
            $display("FAIL update_frame_done dut%0d: got %b, want 1", d, get_fd(d));
         end
         checks++;
         if (get_busy(d) !== 1'b0) begin
            errors++;
            $display("FAIL update_busy dut%0d: got %b, want 0", d, get_busy(d));
         end
         checks++;
         if (get_wa(d) !== 10'd767 || get_pd(d) !== 8'hFF) begin
            errors++;
            $display("FAIL update_hold dut%0d: got %0d/%h, want 767/ff", d, get_wa(d), get_pd(d));
         end
      end
      if (fs_upd) begin
         hc = 10'd0;
         vc = 10'd0;
      end
      model_update(run_v);
      tick();
      random_hv();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (get_fd(d) !== 1'b0 || get_busy(d) !== 1'b0) begin
            errors++;
            $display("FAIL idle_flags dut%0d: frame_done=%b busy=%b, want 0 0", d, get_fd(d), get_busy(d));
         end
         checks++;
         if (get_wa(d) !== 10'd767 || get_pd(d) !== 8'hFF) begin
            errors++;
            $display("FAIL idle_hold dut%0d: got %0d/%h, want 767/ff", d, get_wa(d), get_pd(d));
         end
      end
      if (fs_upd) begin
         hold_bad = 0;
         repeat (4) begin
            tick();
            if (busy0 !== 1'b0 || busy1 !== 1'b0) hold_bad++;
         end
         checks++;
         if (hold_bad != 0) begin
            errors++;
            $display("FAIL fs_in_update: busy seen in %0d cycles after missed fs, want 0", hold_bad);
         end
      end
   endtask

   task automatic test_reset();
      int bad[2];
      reset = 1'b1;
      run   = 1'b0;
      hc    = 10'd5;
      vc    = 10'd5;
      repeat (3) tick();
      reset = 1'b0;
      model_reset();
      checks++;
      if (wa0 !== 10'd0 || pd0 !== 8'h00 || busy0 !== 1'b0 || fd0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got addr=%0d data=%h busy=%b fd=%b, want 0 00 0 0", wa0, pd0, busy0, fd0);
      end
      bad[0] = 0;
      bad[1] = 0;
      repeat (20) begin
         tick();
         for (int d = 0; d < 2; d++)
            if (get_wa(d) !== 10'd0 || get_pd(d) !== 8'h00 || get_busy(d) !== 1'b0 || get_fd(d) !== 1'b0)
               bad[d]++;
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (bad[d] != 0) begin
            errors++;
            $display("FAIL reset_idle dut%0d: %0d cycles left reset values, want 0", d, bad[d]);
         end
      end
   endtask

   task automatic test_sweep();
      int         addrs[6] = '{0, 33, 100, 101, 132, 133};
      logic [7:0] cols[6]  = '{8'hFF, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
      do_frame(1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (cap[0][addrs[k]] !== cols[k]) begin
            errors++;
            $display("FAIL sweep_cell addr %0d: got %h, want %h", addrs[k], cap[0][addrs[k]], cols[k]);
         end
      end
   endtask

   task automatic test_divider();
      int fg_addrs[4] = '{133, 134, 165, 166};
      do_reset();
      for (int f = 0; f < 4; f++) begin
         do_frame(1'b1, 1'b0);
         checks++;
         if (first_fg(0) != 100) begin
            errors++;
            $display("FAIL divider_hold frame %0d: object starts at addr %0d, want 100", f + 1, first_fg(0));
         end
      end
      do_frame(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap[0][fg_addrs[k]] !== 8'hE0) begin
            errors++;
            $display("FAIL divider_step addr %0d: got %h, want e0", fg_addrs[k], cap[0][fg_addrs[k]]);
         end
      end
   endtask

   task automatic test_bounce();
      int exp_x[4] = '{29, 30, 29, 28};
      do_reset();
      for (int f = 0; f < 4; f++) begin
         do_frame(1'b1, 1'b0);
         checks++;
         if (first_fg(1) % 32 != exp_x[f]) begin
            errors++;
            $display("FAIL bounce_x sweep %0d: got x=%0d, want %0d", f + 1, first_fg(1) % 32, exp_x[f]);
         end
      end
   endtask

   task automatic test_run_freeze();
      logic [7:0] ref_frame [768];
      int diffs;
      do_reset();
      for (int f = 0; f < 6; f++) begin
         do_frame(1'b0, 1'b0);
         if (f == 0)
            for (int i = 0; i < 768; i++) ref_frame[i] = cap[0][i];
         diffs = 0;
         for (int i = 0; i < 768; i++)
            if (cap[0][i] !== ref_frame[i]) diffs++;
         checks++;
         if (first_fg(0) != 100 || diffs != 0) begin
            errors++;
            $display("FAIL run_freeze frame %0d: object addr %0d with %0d changed cells, want 100 and 0",
                     f + 1, first_fg(0), diffs);
         end
      end
   endtask

   task automatic test_restart();
      int bad;
      do_reset();
      run = 1'b1;
      pulse_fs();
      bad = 0;
      repeat (200) begin
         if (fd0 !== 1'b0 || fd1 !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL restart_early_done: frame_done in %0d cycles, want 0", bad);
      end
      do_frame(1'b1, 1'b0);
   endtask

   task automatic test_fs_in_update();
      do_reset();
      do_frame(1'b1, 1'b1);
      do_frame(1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      int bad;
      do_reset();
      run = 1'b1;
      pulse_fs();
      n = 0;
      while (wa0 !== 10'd400 && n < 1000) begin
         tick();
         n++;
      end
      checks++;
      if (wa0 !== 10'd400) begin
         errors++;
         $display("FAIL midreset_wait: write_addr got %0d after %0d cycles, want 400", wa0, n);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (get_wa(d) !== 10'd0 || get_busy(d) !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values dut%0d: got addr=%0d busy=%b, want 0 0", d, get_wa(d), get_busy(d));
         end
      end
      bad = 0;
      repeat (20) begin
         tick();
         if (busy0 !== 1'b0 || busy1 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midreset_quiet: busy in %0d cycles before fs, want 0", bad);
      end
      do_frame(1'b1, 1'b0);
      checks++;
      if (first_fg(0) != 100) begin
         errors++;
         $display("FAIL midreset_object: object addr %0d, want 100", first_fg(0));
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int f = 0; f < 10; f++) begin
         repeat ($urandom_range(0, 20)) begin
            random_hv();
            tick();
         end
         do_frame(1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      hc    = 10'd5;
      vc    = 10'd5;
      test_reset();
      test_sweep();
      test_divider();
      test_bounce();
      test_run_freeze();
      test_restart();
      test_fs_in_update();
      test_reset_mid_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
